// File: rtl/receive_slot_scheduler_if.sv
// Bundle of parser, drain and status signals around receive_slot_scheduler.
// master = parser/consumer side, slave = the scheduler itself.
interface receive_slot_scheduler_if #(
  parameter int RECEIVE_QUE_SLOTS = 4,
  parameter int COUNTER_WIDTH     = 16
);
  localparam int IW = $clog2(RECEIVE_QUE_SLOTS);

  logic [RECEIVE_QUE_SLOTS-1:0] packet_data_valid;
  logic [RECEIVE_QUE_SLOTS-1:0] good_packet;
  logic [RECEIVE_QUE_SLOTS-1:0] bad_packet;
  logic [RECEIVE_QUE_SLOTS-1:0] receive_slot_enable;
  logic [RECEIVE_QUE_SLOTS-1:0] slot_ready;
  logic                         drain_valid;
  logic [IW-1:0]                drain_slot;
  logic                         drain_ready;
  logic                         drain_done;
  logic                         protocol_error;
  logic [COUNTER_WIDTH-1:0]     good_frame_count;
  logic [COUNTER_WIDTH-1:0]     bad_frame_count;

  modport master (
    output packet_data_valid, good_packet, bad_packet, drain_ready, drain_done,
    input  receive_slot_enable, slot_ready, drain_valid, drain_slot,
           protocol_error, good_frame_count, bad_frame_count
  );

  modport slave (
    input  packet_data_valid, good_packet, bad_packet, drain_ready, drain_done,
    output receive_slot_enable, slot_ready, drain_valid, drain_slot,
           protocol_error, good_frame_count, bad_frame_count
  );
endinterface

// File: rtl/receive_slot_scheduler.sv
// Receive slot lifecycle tracker, single-slot offer and round-robin drain arbiter.
// Define RECEIVE_SLOT_STATISTICS_EN to build the saturating good/bad frame counters.
module receive_slot_scheduler #(
  parameter int RECEIVE_QUE_SLOTS = 4,
  parameter int COUNTER_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  receive_slot_scheduler_if.slave bus
);
  localparam int N  = RECEIVE_QUE_SLOTS;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S_FREE, S_FILLING, S_READY, S_DRAINING} slot_state_t;
  typedef enum logic [1:0] {A_IDLE, A_GRANT, A_BUSY} arb_state_t;

  slot_state_t   slot_q [N];
  slot_state_t   slot_d [N];
  logic [N-1:0]  enable_q, enable_d;
  logic          perr_q, perr_d;
  arb_state_t    arb_q;
  logic [IW-1:0] grant_q, rr_q;
  logic          drain_valid_q;

  logic          handshake, done_ok, offer_found, rr_found;
  logic [N-1:0]  good_ev, bad_ev, ready_vec;
  logic [IW-1:0] rr_pick;
  logic [IW:0]   rr_cand;

  assign handshake = (arb_q == A_GRANT) && bus.drain_ready;
  assign done_ok   = (arb_q == A_BUSY) && bus.drain_done;

  always_comb begin
    perr_d      = perr_q || (bus.drain_done && (arb_q != A_BUSY));
    enable_d    = '0;
    offer_found = 1'b0;
    good_ev     = '0;
    bad_ev      = '0;
    for (int k = 0; k < N; k++) begin
      slot_d[k] = slot_q[k];
      case (slot_q[k])
        S_FREE:     if (bus.packet_data_valid[k] && enable_q[k]) slot_d[k] = S_FILLING;
        // bad wins when both strobes fire together
        S_FILLING:  if (bus.bad_packet[k]) begin
                      slot_d[k] = S_FREE;
                      bad_ev[k] = 1'b1;
                    end else if (bus.good_packet[k]) begin
                      slot_d[k]  = S_READY;
                      good_ev[k] = 1'b1;
                    end
        S_READY:    if (handshake && grant_q == IW'(k)) slot_d[k] = S_DRAINING;
        S_DRAINING: if (done_ok && grant_q == IW'(k)) slot_d[k] = S_FREE;
        default:    slot_d[k] = S_FREE;
      endcase
      if (slot_q[k] != S_FILLING) begin
        if (bus.good_packet[k] || bus.bad_packet[k]) perr_d = 1'b1;
        if (bus.packet_data_valid[k] && !enable_q[k]) perr_d = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!offer_found && slot_d[k] == S_FREE) begin
        enable_d[k] = 1'b1;
        offer_found = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q[gi] <= S_FREE;
        else     slot_q[gi] <= slot_d[gi];
      end
      assign ready_vec[gi] = (slot_q[gi] == S_READY);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      enable_q <= enable_d;
      perr_q   <= perr_d;
    end
  end

  // first READY slot at or after rr_q, wrapping
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = rr_q;
    rr_cand  = '0;
    for (int i = 0; i < N; i++) begin
      rr_cand = {1'b0, rr_q} + (IW+1)'(i);
      if (rr_cand >= (IW+1)'(N)) rr_cand = rr_cand - (IW+1)'(N);
      if (!rr_found && ready_vec[rr_cand[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_q         <= A_IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      drain_valid_q <= 1'b0;
    end else begin
      case (arb_q)
        A_IDLE: if (rr_found) begin
          grant_q       <= rr_pick;
          drain_valid_q <= 1'b1;
          arb_q         <= A_GRANT;
        end
        A_GRANT: if (bus.drain_ready) begin
          drain_valid_q <= 1'b0;
          rr_q          <= (grant_q == IW'(N-1)) ? '0 : grant_q + IW'(1);
          arb_q         <= A_BUSY;
        end
        A_BUSY: if (bus.drain_done) arb_q <= A_IDLE;
        default: arb_q <= A_IDLE;
      endcase
    end
  end

`ifdef RECEIVE_SLOT_STATISTICS_EN
  localparam int SW = COUNTER_WIDTH + IW + 1;
  logic [COUNTER_WIDTH-1:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [SW-1:0]            good_sum, bad_sum;

  // several slots can complete in one cycle, so add the event count then clamp
  always_comb begin
    good_sum = SW'(good_cnt_q);
    bad_sum  = SW'(bad_cnt_q);
    for (int k = 0; k < N; k++) begin
      good_sum = good_sum + SW'(good_ev[k]);
      bad_sum  = bad_sum + SW'(bad_ev[k]);
    end
    good_cnt_d = (good_sum > SW'({COUNTER_WIDTH{1'b1}})) ? '1 : good_sum[COUNTER_WIDTH-1:0];
    bad_cnt_d  = (bad_sum > SW'({COUNTER_WIDTH{1'b1}})) ? '1 : bad_sum[COUNTER_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign bus.good_frame_count = good_cnt_q;
  assign bus.bad_frame_count  = bad_cnt_q;
`else
  logic unused_ev;
  assign unused_ev            = ^{good_ev, bad_ev};
  assign bus.good_frame_count = {COUNTER_WIDTH{1'b0}};
  assign bus.bad_frame_count  = {COUNTER_WIDTH{1'b0}};
`endif

  assign bus.receive_slot_enable = enable_q;
  assign bus.slot_ready          = ready_vec;
  assign bus.drain_valid         = drain_valid_q;
  assign bus.drain_slot          = grant_q;
  assign bus.protocol_error      = perr_q;
endmodule

// File: tb/tb_receive_slot_scheduler.sv
// Scoreboard bench for receive_slot_scheduler: expected grant slots are queued as
// frames complete and popped as grants appear; counters follow RECEIVE_SLOT_STATISTICS_EN.
module tb_receive_slot_scheduler;
  localparam int N       = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  receive_slot_scheduler_if #(.RECEIVE_QUE_SLOTS(N), .COUNTER_WIDTH(CW)) bus();

  receive_slot_scheduler #(.RECEIVE_QUE_SLOTS(N), .COUNTER_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int exp_good = 0;
  int exp_bad  = 0;
  int sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_exp(input int v);
`ifdef RECEIVE_SLOT_STATISTICS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic bump(inout int v);
    if (v < CNT_MAX) v++;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_good_cnt"}, 32'(bus.good_frame_count), cnt_exp(exp_good));
    check_eq({tag, "_bad_cnt"}, 32'(bus.bad_frame_count), cnt_exp(exp_bad));
  endtask

  task automatic drain_one();
    int n = 0;
    int exp_slot = -1;
    while (!bus.drain_valid && n < 20) begin
      cyc();
      n++;
    end
    check_eq("grant_seen", 32'(bus.drain_valid), 1);
    if (!bus.drain_valid) return;
    check_eq("sb_pending", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) exp_slot = sb.pop_front();
    check_eq("drain_slot", 32'(bus.drain_slot), exp_slot);
    $display("drain grant slot %0d (expected %0d)", bus.drain_slot, exp_slot);
    bus.drain_ready = 1'b1;
    cyc();
    bus.drain_ready = 1'b0;
    check_eq("valid_drop", 32'(bus.drain_valid), 0);
    bus.drain_done = 1'b1;
    cyc();
    bus.drain_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.packet_data_valid = '0;
    bus.good_packet       = '0;
    bus.bad_packet        = '0;
    bus.drain_ready       = 1'b0;
    bus.drain_done        = 1'b0;

    // reset values
    cyc();
    cyc();
    check_eq("rst_enable", 32'(bus.receive_slot_enable), 0);
    check_eq("rst_valid", 32'(bus.drain_valid), 0);
    check_eq("rst_slot", 32'(bus.drain_slot), 0);
    check_eq("rst_ready", 32'(bus.slot_ready), 0);
    check_eq("rst_perr", 32'(bus.protocol_error), 0);
    check_counts("rst");
    rst = 1'b0;
    cyc();
    check_eq("first_offer", 32'(bus.receive_slot_enable), 32'b0001);
    check_eq("idle_valid", 32'(bus.drain_valid), 0);

    // single frame through slot 0
    bus.packet_data_valid = 4'b0001;
    cyc();
    bus.packet_data_valid = '0;
    check_eq("offer_after_fill", 32'(bus.receive_slot_enable), 32'b0010);
    bus.good_packet = 4'b0001;
    cyc();
    bus.good_packet = '0;
    sb.push_back(0);
    bump(exp_good);
    check_eq("ready_s0", 32'(bus.slot_ready), 32'b0001);
    check_counts("t1");
    drain_one();
    check_eq("offer_back_s0", 32'(bus.receive_slot_enable), 32'b0001);

    // fill all four good, grants in order
    for (int k = 0; k < N; k++) begin
      check_eq("offer_seq", 32'(bus.receive_slot_enable), 32'(1 << k));
      bus.packet_data_valid = N'(1 << k);
      cyc();
      bus.packet_data_valid = '0;
      bus.good_packet = N'(1 << k);
      cyc();
      bus.good_packet = '0;
      sb.push_back(k);
      bump(exp_good);
    end
    check_eq("full_offer", 32'(bus.receive_slot_enable), 0);
    check_eq("full_ready", 32'(bus.slot_ready), 32'b1111);
    for (int k = 0; k < N; k++) drain_one();

    // refill 0 and 2 together (slot 1 bad): rr from 0 gives 0 then 2
    check_eq("offer_refill", 32'(bus.receive_slot_enable), 32'b0001);
    for (int k = 0; k < 3; k++) begin
      bus.packet_data_valid = N'(1 << k);
      cyc();
    end
    bus.packet_data_valid = '0;
    check_eq("offer_s3", 32'(bus.receive_slot_enable), 32'b1000);
    bus.good_packet = 4'b0101;
    bus.bad_packet  = 4'b0010;
    cyc();
    bus.good_packet = '0;
    bus.bad_packet  = '0;
    sb.push_back(0);
    sb.push_back(2);
    bump(exp_good);
    bump(exp_good);
    bump(exp_bad);
    check_eq("offer_after_bad1", 32'(bus.receive_slot_enable), 32'b0010);
    check_counts("t3");
    drain_one();
    drain_one();

    // all slots filling, then bad[2] reopens slot 2
    for (int k = 0; k < N; k++) begin
      bus.packet_data_valid = N'(1 << k);
      cyc();
    end
    bus.packet_data_valid = '0;
    check_eq("all_busy_offer", 32'(bus.receive_slot_enable), 0);
    bus.bad_packet = 4'b0100;
    cyc();
    bus.bad_packet = '0;
    bump(exp_bad);
    check_eq("offer_s2", 32'(bus.receive_slot_enable), 32'b0100);
    check_counts("bad2");
    // good+bad on slot 1 counts as bad
    bus.good_packet = 4'b0011;
    bus.bad_packet  = 4'b0010;
    cyc();
    bus.good_packet = '0;
    bus.bad_packet  = '0;
    sb.push_back(0);
    bump(exp_good);
    bump(exp_bad);
    check_eq("offer_s1", 32'(bus.receive_slot_enable), 32'b0010);
    check_eq("ready_only_s0", 32'(bus.slot_ready), 32'b0001);
    check_counts("both1");
    bus.bad_packet = 4'b1000;
    cyc();
    bus.bad_packet = '0;
    bump(exp_bad);
    drain_one();
    check_eq("perr_clean", 32'(bus.protocol_error), 0);

    // good on a FREE slot is an error and sticks
    bus.good_packet = 4'b1000;
    cyc();
    bus.good_packet = '0;
    check_eq("perr_set", 32'(bus.protocol_error), 1);
    check_eq("ready_no_s3", 32'(bus.slot_ready), 0);
    cyc();
    cyc();
    check_eq("perr_sticky", 32'(bus.protocol_error), 1);
    check_counts("perr");

    // saturation over 17 good frames
    for (int f = 0; f < 17; f++) begin
      bus.packet_data_valid = 4'b0001;
      cyc();
      bus.packet_data_valid = '0;
      bus.good_packet = 4'b0001;
      cyc();
      bus.good_packet = '0;
      sb.push_back(0);
      bump(exp_good);
      check_eq("sat_good_cnt", 32'(bus.good_frame_count), cnt_exp(exp_good));
      drain_one();
    end
    check_counts("sat");
    check_eq("perr_still", 32'(bus.protocol_error), 1);

    // reset mid-operation with a grant pending
    bus.packet_data_valid = 4'b0001;
    cyc();
    bus.packet_data_valid = '0;
    bus.good_packet = 4'b0001;
    cyc();
    bus.good_packet = '0;
    cyc();
    check_eq("pre_rst_valid", 32'(bus.drain_valid), 1);
    rst = 1'b1;
    #1;
    exp_good = 0;
    exp_bad  = 0;
    check_eq("mid_rst_valid", 32'(bus.drain_valid), 0);
    check_eq("mid_rst_enable", 32'(bus.receive_slot_enable), 0);
    check_eq("mid_rst_ready", 32'(bus.slot_ready), 0);
    check_eq("mid_rst_perr", 32'(bus.protocol_error), 0);
    check_counts("mid_rst");
    cyc();
    rst = 1'b0;
    cyc();
    check_eq("post_rst_offer", 32'(bus.receive_slot_enable), 32'b0001);
    check_eq("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
